// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between two masters
// (port 0 = processor, port 1 = DMA/boot loader).
//   clk, reset (async, active low)
//   reqN/lockN/weN/addrN/wdataN : requester N access request
//   gntN  : port N owns memory this cycle
//   ackN  : port N access performed this cycle
//   rdataN: memory read data (valid when ackN & ~weN)
//   mem_addr/mem_wdata/mem_we/mem_rdata : unified memory port
// One access per cycle, round-robin on contention, locked bursts capped at
// MAX_BURST consecutive grants.
module mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             lock0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             ack0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             lock1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          own_q, own_d;
  logic          last_q, last_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  logic req_own, lock_own;

  assign req_own  = own_q ? req1  : req0;
  assign lock_own = own_q ? lock1 : lock0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;   // port 0 wins the first contended grant
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next state: hold a locked owner until its burst cap, else re-arbitrate.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    if (state_q == BUSY && req_own && lock_own && bcnt_q < BMAX) begin
      bcnt_d = bcnt_q + 1'b1;
    end else if (req0 || req1) begin
      state_d = BUSY;
      own_d   = (req0 && req1) ? ~last_q : req1;
      last_d  = own_d;
      bcnt_d  = '0;
    end else begin
      state_d = IDLE;
    end
  end

  // Outputs: owner drives the memory port; a dropped req suppresses the access.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == BUSY) begin
      if (own_q) begin
        gnt1      = 1'b1;
        ack1      = req1;
        mem_we    = we1 & req1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end else begin
        gnt0      = 1'b1;
        ack0      = req0;
        mem_we    = we0 & req0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
    end
  end

  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 0, lock0 = 0, we0 = 0;
  logic [W-1:0] addr0 = '0, wdata0 = '0;
  logic         req1 = 0, lock1 = 0, we1 = 0;
  logic [W-1:0] addr1 = '0, wdata1 = '0;
  logic         gnt0, ack0, gnt1, ack1, mem_we;
  logic [W-1:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; lock0 = 0; we0 = 0;
    req1 = 0; lock1 = 0; we1 = 0;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_gnt", {30'd0, gnt0, gnt1}, 0);
    chk("rst_ack", {30'd0, ack0, ack1}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    tick();
    reset = 1'b1;

    // 1: single read from port 0
    req0 = 1; we0 = 0; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_gnt0", {31'd0, gnt0}, 1);
    chk("rd_ack0", {31'd0, ack0}, 1);
    chk("rd_gnt1", {31'd0, gnt1}, 0);
    chk("rd_addr", mem_addr, 32'h10);
    chk("rd_data", rdata0, 32'hDEADBEEF);
    chk("rd_we", {31'd0, mem_we}, 0);
    tick();             // req still sampled high: regranted, then dropped
    req0 = 0;
    #1;
    chk("rd_drop_ack", {31'd0, ack0}, 0);
    tick();
    chk("rd_idle", {30'd0, gnt0, gnt1}, 0);

    // 2: contention without lock alternates, port 0 first after reset
    do_reset();
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("alt_gnt%0d", i), {30'd0, gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    idle_inputs();

    // 3: locked burst by port 1 capped at 4 grants
    do_reset();
    req1 = 1; lock1 = 1;
    tick();
    req0 = 1;
    chk("bur_g1_0", {30'd0, gnt0, gnt1}, 2'b01);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("bur_g1_%0d", i), {30'd0, gnt0, gnt1}, 2'b01);
    end
    tick();
    chk("bur_g0", {30'd0, gnt0, gnt1}, 2'b10);
    tick();
    chk("bur_g1_again", {30'd0, gnt0, gnt1}, 2'b01);
    idle_inputs();

    // 4: single write from port 0
    do_reset();
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h12345678;
    tick();
    chk("wr_we", {31'd0, mem_we}, 1);
    chk("wr_ack0", {31'd0, ack0}, 1);
    chk("wr_addr", mem_addr, 32'h20);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    tick();
    req0 = 0;
    #1;
    chk("wr_we_off", {31'd0, mem_we}, 0);
    chk("wr_ack_off", {31'd0, ack0}, 0);
    tick();
    chk("wr_idle_we", {31'd0, mem_we}, 0);
    idle_inputs();

    // 5: async reset mid-burst while port 1 owns
    do_reset();
    req1 = 1; lock1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'hA5A5A5A5;
    tick();
    tick();
    chk("ar_pre_gnt1", {31'd0, gnt1}, 1);
    chk("ar_pre_we", {31'd0, mem_we}, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_gnt1", {31'd0, gnt1}, 0);
    chk("ar_ack1", {31'd0, ack1}, 0);
    chk("ar_we", {31'd0, mem_we}, 0);
    chk("ar_addr", mem_addr, 0);
    lock1 = 0; we1 = 0; req0 = 1;
    #1 reset = 1'b1;
    tick();
    chk("ar_first", {30'd0, gnt0, gnt1}, 2'b10);
    idle_inputs();

    // 6a: owner drops req mid-burst, competitor waiting
    do_reset();
    req1 = 1; lock1 = 1; we1 = 1; addr1 = 32'h80;
    tick();
    chk("dr_c1_ack1", {31'd0, ack1}, 1);
    tick();
    req1 = 0; req0 = 1;
    #1;
    chk("dr_c2_gnt1", {31'd0, gnt1}, 1);
    chk("dr_c2_ack1", {31'd0, ack1}, 0);
    chk("dr_c2_we", {31'd0, mem_we}, 0);
    tick();
    chk("dr_next", {30'd0, gnt0, gnt1}, 2'b10);
    idle_inputs();

    // 6b: owner drops req mid-burst, nobody else -> IDLE
    do_reset();
    req1 = 1; lock1 = 1;
    tick();
    tick();
    req1 = 0;
    tick();
    chk("dr_idle", {30'd0, gnt0, gnt1}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter sharing the single unified memory port (addr, writedata, memwrite, readdata) between the multi-cycle processor and a second master (DMA/boot loader).
- Grants one access per cycle, round-robin on ties.
- Supports a lock signal for bounded back-to-back bursts.
- Sits between the mips core / loader and the unified memory.

Parameters:
- WIDTH, 32, data and address width.
- MAX_BURST, 4, max consecutive grants to one locked owner before forced release (>=1).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req0  input  1  port 0 (processor) request
- lock0  input  1  port 0 wants to keep ownership after the current access
- we0  input  1  port 0 write enable
- addr0  input  WIDTH  port 0 address
- wdata0  input  WIDTH  port 0 write data
- gnt0  output  1  port 0 owns memory this cycle
- ack0  output  1  port 0 access performed this cycle
- rdata0  output  WIDTH  read data to port 0
- req1, lock1, we1, addr1, wdata1, gnt1, ack1, rdata1: same as port 0, for port 1
- mem_addr  output  WIDTH  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_we  output  1  memory write enable
- mem_rdata  input  WIDTH  combinational read data from memory

Behaviour:
- States:
  - IDLE: no owner.
  - BUSY: owner register `own` valid.
- Registers:
  - state
  - own (1b)
  - last (1b, last granted port)
  - bcnt (counter wide enough to hold MAX_BURST-1)
- Reset (reset=0, async): state=IDLE, own=0, last=1, bcnt=0. Outputs combinationally go to: gnt*=0, ack*=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Outputs when state=IDLE: all gnt/ack=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Outputs when state=BUSY, driven by owner X:
  - gntX=1.
  - mem_addr=addrX, mem_wdata=wdataX.
  - mem_we=weX & reqX.
  - ackX=reqX.
  - Other port's gnt/ack=0.
- rdataX=mem_rdata for both ports at all times. Data is valid only when ackX=1 and weX=0.
- Latency: req sampled at rising edge; access occurs in the following cycle. A write commits at the end of the ack cycle. A read is valid in the ack cycle.
- Next-state arbitration, evaluated at every edge:
  1. Hold: if state=BUSY & req_own & lock_own & bcnt<MAX_BURST-1, then stay BUSY with same own, bcnt+=1.
  2. Otherwise (IDLE, or release from BUSY):
     - Both req: grant port != last.
     - One req: grant that port.
     - None: go IDLE.
     - On grant: state=BUSY, own=winner, last=winner, bcnt=0.
- No bubble on handoff: BUSY→BUSY with a new owner in consecutive cycles is legal.
- A released owner still requesting, with no competitor, is regranted (bcnt restarts at 0).
- Owner drops req during BUSY:
  - mem_we=0, ack=0 that cycle; no access occurs.
  - Rule 2 applies at the next edge.
- MAX_BURST=1: lock has no effect; pure alternation under contention.
- lock is ignored on the non-owner port and on the first grant cycle's arbitration.
- Requesters must hold addr/we/wdata stable while req=1 until ack.

Test Plan:
1. Reset release, then req0=1, we0=0, addr0=0x10, mem_rdata=0xDEADBEEF for 1 cycle → next cycle gnt0=ack0=1, mem_addr=0x10, rdata0=0xDEADBEEF, mem_we=0; IDLE afterwards.
2. req0=req1=1 held first after reset, lock=0 → grants alternate 0,1,0,1 each cycle, never both gnt high, no IDLE cycles.
3. MAX_BURST=4, req1=lock1=1 granted first, req0=1 held → gnt1 for exactly 4 consecutive cycles, then gnt0 for 1 cycle, then gnt1 again.
4. Port 0 write: we0=1, addr0=0x20, wdata0=0x12345678 → mem_we=1 for exactly one cycle with mem_addr=0x20, mem_wdata=0x12345678; ack0 pulse coincident.
5. Reset driven 0 mid-BUSY (port 1 owning, mid-burst) → gnt1, ack1, mem_we fall immediately, without waiting for clk. After release with both req → port 0 granted first.
6. Owner port 1 locked burst, req1 dropped in cycle 2 → that cycle mem_we=0, ack1=0; next edge grants port 0 if req0=1, else IDLE.
